// File: rtl/sev_seg_scan.sv
// Eight-digit seven-segment scan: prescaled digit stepping, frame-synchronous shadow load, active-low decode.
// seg_n is combinational from registered state; new content appears on the first cycle of the next frame.
module sev_seg_scan #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  dp_in,
  output logic [2:0]  digit_idx,
  output logic [7:0]  seg_n,
  output logic        frame_done,
  output logic        pending
);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       digit_q, digit_d;
  logic             fdone_q;
  logic             pend_q, pend_d;
  logic [31:0]      stg_val_q, stg_val_d, disp_val_q, disp_val_d;
  logic [7:0]       stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic [7:0]       stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic             tick, wrap;

  assign tick = (presc_q == CNT_W'(TICK_DIV - 1));
  assign wrap = tick && (digit_q == 3'd7);

  always_comb begin
    presc_d      = tick ? '0 : presc_q + CNT_W'(1);
    digit_d      = tick ? digit_q + 3'd1 : digit_q;
    pend_d       = pend_q;
    stg_val_d    = stg_val_q;
    stg_blank_d  = stg_blank_q;
    stg_dp_d     = stg_dp_q;
    disp_val_d   = disp_val_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;
    if (wrap) begin
      // A load landing on the wrap edge bypasses staging so it is not delayed a whole frame.
      if (load) begin
        disp_val_d   = value_in;
        disp_blank_d = blank_in;
        disp_dp_d    = dp_in;
      end else if (pend_q) begin
        disp_val_d   = stg_val_q;
        disp_blank_d = stg_blank_q;
        disp_dp_d    = stg_dp_q;
      end
      pend_d = 1'b0;
    end else if (load) begin
      stg_val_d   = value_in;
      stg_blank_d = blank_in;
      stg_dp_d    = dp_in;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      digit_q      <= 3'd0;
      fdone_q      <= 1'b0;
      pend_q       <= 1'b0;
      stg_val_q    <= '0;
      stg_blank_q  <= '0;
      stg_dp_q     <= '0;
      disp_val_q   <= '0;
      disp_blank_q <= 8'hFF;
      disp_dp_q    <= '0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      fdone_q      <= wrap;
      pend_q       <= pend_d;
      stg_val_q    <= stg_val_d;
      stg_blank_q  <= stg_blank_d;
      stg_dp_q     <= stg_dp_d;
      disp_val_q   <= disp_val_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  logic [2:0] mask_bit;
  logic [4:0] nib_sh;
  logic [3:0] nib;
  logic [6:0] glyph_n;

  // Digit 0 is the most significant nibble and mask bit 7.
  assign mask_bit = ~digit_q;
  assign nib_sh   = {mask_bit, 2'b00};
  assign nib      = 4'(disp_val_q >> nib_sh);

  always_comb begin
    glyph_n = 7'b1111111;
    case (nib)
      4'h0: glyph_n = 7'b1000000;
      4'h1: glyph_n = 7'b1111001;
      4'h2: glyph_n = 7'b0100100;
      4'h3: glyph_n = 7'b0110000;
      4'h4: glyph_n = 7'b0011001;
      4'h5: glyph_n = 7'b0010010;
      4'h6: glyph_n = 7'b0000010;
      4'h7: glyph_n = 7'b1111000;
      4'h8: glyph_n = 7'b0000000;
      4'h9: glyph_n = 7'b0010000;
      4'hA: glyph_n = 7'b0001000;
      4'hB: glyph_n = 7'b0000011;
      4'hC: glyph_n = 7'b1000110;
      4'hD: glyph_n = 7'b0100001;
      4'hE: glyph_n = 7'b0000110;
      4'hF: glyph_n = 7'b0001110;
      default: glyph_n = 7'b1111111;
    endcase
  end

  assign seg_n      = disp_blank_q[mask_bit] ? 8'hFF : {~disp_dp_q[mask_bit], glyph_n};
  assign digit_idx  = digit_q;
  assign frame_done = fdone_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan with a cycle-count reference model, a vector table and corner-case sequences.
module tb_sev_seg_scan;
  localparam int TD    = 4;
  localparam int FRAME = 8 * TD;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value_in = '0;
  logic [7:0]  blank_in = '0;
  logic [7:0]  dp_in = '0;
  logic [2:0]  digit_idx;
  logic [7:0]  seg_n;
  logic        frame_done;
  logic        pending;

  sev_seg_scan #(.TICK_DIV(TD), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .blank_in(blank_in),
    .dp_in(dp_in), .digit_idx(digit_idx), .seg_n(seg_n), .frame_done(frame_done), .pending(pending));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: n counts clock edges since reset; digit and frame position follow by arithmetic.
  int unsigned n = 0;
  logic [31:0] m_val = '0, s_val = '0;
  logic [7:0]  m_blank = 8'hFF, m_dp = '0, s_blank = '0, s_dp = '0;
  bit          m_pend = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_val = '0; m_blank = 8'hFF; m_dp = '0;
      s_val = '0; s_blank = '0; s_dp = '0; m_pend = 1'b0;
    end else begin
      if (n % FRAME == FRAME - 1) begin
        if (load) begin
          m_val = value_in; m_blank = blank_in; m_dp = dp_in;
        end else if (m_pend) begin
          m_val = s_val; m_blank = s_blank; m_dp = s_dp;
        end
        m_pend = 1'b0;
      end else if (load) begin
        s_val = value_in; s_blank = blank_in; s_dp = dp_in; m_pend = 1'b1;
      end
      n++;
    end
  end

  function automatic logic [7:0] exp_seg(logic [31:0] v, logic [7:0] b, logic [7:0] d, int k);
    logic [3:0] nib;
    nib = 4'((v >> (4 * (7 - k))) & 32'hF);
    if (b[7-k]) return 8'hFF;
    return {~d[7-k], GLYPH[nib]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic check_all();
    int d;
    d = (n / TD) % 8;
    chk("digit_idx", 32'(digit_idx), 32'(d));
    chk("frame_done", 32'(frame_done), 32'((n % FRAME == 0) && (n != 0)));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("seg_n", 32'(seg_n), 32'(exp_seg(m_val, m_blank, m_dp, d)));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to(input int phase);
    int guard;
    guard = 0;
    while (n % FRAME != phase && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    if (n % FRAME != phase) begin
      total++; bad++;
      $display("FAIL run_to: phase %0d not reached", phase);
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] b, input logic [7:0] d);
    load = 1'b1; value_in = v; blank_in = b; dp_in = d;
    step();
    load = 1'b0;
  endtask

  typedef struct {
    logic [31:0] val;
    logic [7:0]  blank;
    logic [7:0]  dp;
    int          digit;
    logic [7:0]  seg;
  } vec_t;

  vec_t vecs [12];
  int   pulses;
  bit   saw;

  initial begin
    vecs[0]  = '{32'h01234567, 8'h00, 8'h00, 0, 8'hC0};
    vecs[1]  = '{32'h01234567, 8'h00, 8'h00, 1, 8'hF9};
    vecs[2]  = '{32'h01234567, 8'h00, 8'h00, 7, 8'hF8};
    vecs[3]  = '{32'h01234567, 8'h80, 8'h01, 0, 8'hFF};
    vecs[4]  = '{32'h01234567, 8'h80, 8'h01, 7, 8'h78};
    vecs[5]  = '{32'h01234567, 8'h80, 8'h01, 3, 8'hB0};
    vecs[6]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 0, 8'h00};
    vecs[7]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 2, 8'h08};
    vecs[8]  = '{32'h89ABCDEF, 8'h00, 8'hFF, 7, 8'h0E};
    vecs[9]  = '{32'hFEDCBA98, 8'h00, 8'h00, 1, 8'h86};
    vecs[10] = '{32'hFEDCBA98, 8'h00, 8'h00, 3, 8'hC6};
    vecs[11] = '{32'hFEDCBA98, 8'h00, 8'h00, 4, 8'h83};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_digit", 32'(digit_idx), 0);
    chk("rst_seg", 32'(seg_n), 32'hFF);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_done) pulses++;
    end
    chk("fdone_count", 32'(pulses), 2);

    foreach (vecs[i]) begin
      run_to(10);
      do_load(vecs[i].val, vecs[i].blank, vecs[i].dp);
      chk("vec_pending", 32'(pending), 1);
      run_to(0);
      repeat (vecs[i].digit * TD) step();
      chk($sformatf("vec%0d_seg", i), 32'(seg_n), 32'(vecs[i].seg));
    end

    // Last of two loads in one frame wins.
    run_to(5);
    do_load(32'h11111111, 8'h00, 8'h00);
    run_to(8);
    do_load(32'h22222222, 8'h00, 8'h00);
    run_to(0);
    saw = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      chk("b2b_seg", 32'(seg_n), 32'hA4);
      if (seg_n == 8'hF9) saw = 1'b1;
      step();
    end
    chk("b2b_no_f9", 32'(saw), 0);

    // Load on the wrap edge goes straight to the display.
    run_to(FRAME - 1);
    do_load(32'hFFFFFFFF, 8'h00, 8'h00);
    chk("wrap_pending", 32'(pending), 0);
    chk("wrap_fdone", 32'(frame_done), 1);
    for (int i = 0; i < FRAME; i++) begin
      chk("wrap_seg", 32'(seg_n), 32'h8E);
      step();
    end

    // Reset in the middle of digit 5 with a load pending.
    run_to(10);
    do_load(32'h01234567, 8'h00, 8'h00);
    run_to(5 * TD);
    chk("pre_rst_pending", 32'(pending), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digit", 32'(digit_idx), 0);
    chk("arst_seg", 32'(seg_n), 32'hFF);
    chk("arst_pending", 32'(pending), 0);
    chk("arst_fdone", 32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      chk("post_rst_seg", 32'(seg_n), 32'hFF);
    end

    for (int i = 0; i < 600; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      value_in = $urandom;
      blank_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      dp_in    = 8'($urandom);
      step();
    end
    load = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
